// File: rtl/if_axi_fetch.sv
// Instruction-fetch AXI4 read master: one single-beat read per PC, one outstanding transaction.
// Flush discards the fetch in flight but always completes the AXI handshakes already started.
module if_axi_fetch #(
    parameter logic [3:0]  AXI_ID    = 4'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] pc_in,
    input  logic        fetch_req,
    input  logic        flush,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        fetch_stall,
    output logic        bus_err,
    output logic [3:0]  ARID,
    output logic [31:0] ARADDR,
    output logic [3:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [3:0]  RID,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned WORD_LSB = 2;
    localparam int unsigned AW       = XLEN - WORD_LSB;
    localparam logic [1:0]  RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [AW-1:0]     r_addr;
    logic              r_drop;
    logic              r_arvalid;
    logic [XLEN-1:0]   r_data;
    logic              r_err;
    logic [XLEN-1:0]   r_instr;

    logic              w_idle_req;
    logic              w_misaligned;
    logic              w_rid_ok;
    logic              w_r_accept;
    logic              w_drop;
    logic              w_done_ok;

    assign w_idle_req   = (r_state == ST_IDLE) && fetch_req && !flush;
    assign w_misaligned = (pc_in[WORD_LSB-1:0] != WORD_LSB'(0));
    assign w_rid_ok     = (RID == AXI_ID);
    assign w_r_accept   = (r_state == ST_R) && RVALID && w_rid_ok && RLAST;
    assign w_drop       = r_drop || flush;
    // A flush landing in DONE cancels the delivery before it becomes architectural.
    assign w_done_ok    = (r_state == ST_DONE) && !flush;

    assign ARID    = AXI_ID;
    assign ARADDR  = {r_addr, WORD_LSB'(0)};
    assign ARLEN   = 4'd0;
    assign ARSIZE  = 3'b010;
    assign ARBURST = 2'b01;
    assign ARVALID = r_arvalid;

    // Beats carrying a foreign ID are left on the bus untouched.
    assign RREADY      = (r_state == ST_R) && (!RVALID || w_rid_ok);
    assign fetch_stall = rstn && (w_idle_req || (r_state == ST_AR) || (r_state == ST_R));

    assign instr       = w_done_ok ? r_data : r_instr;
    assign instr_valid = w_done_ok;
    assign bus_err     = w_done_ok && r_err;

    // Fetch sequencer: IDLE -> AR -> R -> DONE, with a drop flag that drains a flushed fetch.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_drop    <= 1'b0;
            r_arvalid <= 1'b0;
            r_data    <= '0;
            r_err     <= 1'b0;
            r_instr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_idle_req) begin
                        r_addr <= pc_in[XLEN-1:WORD_LSB];
                        if (w_misaligned) begin
                            r_data  <= NOP_INSTR;
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_AR;
                        end
                    end
                end
                ST_AR: begin
                    if (flush) begin
                        r_drop <= 1'b1;
                    end
                    if (ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_state   <= ST_R;
                    end
                end
                ST_R: begin
                    if (w_r_accept) begin
                        if (w_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_data  <= (RRESP == RESP_OKAY) ? RDATA : NOP_INSTR;
                            r_err   <= (RRESP != RESP_OKAY);
                            r_state <= ST_DONE;
                        end
                    end else if (flush) begin
                        r_drop <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!flush) begin
                        r_instr <= r_data;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
